ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Single-wire WS2812 NRZ decoder: the receive end of the strip-driver protocol.
- Samples one strip data line on sys_clk (50 MHz, 20 ns), measures high-pulse widths, rebuilds 24-bit GRB pixel words MSB-first, counts pixels and flags frame end on the reset/latch gap.
- Used for loopback self-test of the strip drivers and as the capture front end for the strip-monitor path.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on din (min 2).
- MIN_HIGH, 4: high pulses shorter than this many cycles are glitches (error).
- BIT_THRESH, 20: high width > BIT_THRESH cycles decodes as 1, otherwise 0.
- MAX_HIGH, 45: high width > MAX_HIGH cycles is an error.
- RESET_CYCLES, 2500: din low for this many consecutive cycles = frame end / line idle (50 µs).
- MAX_PIXELS, 128: pixels accepted per frame.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- din  in  1  asynchronous strip data line.
- pixel_data  out  24  last decoded pixel {G,R,B}, held until next pixel_valid.
- pixel_valid  out  1  one-cycle strobe, pixel_data/pixel_index valid.
- pixel_index  out  7  index of the pixel being strobed (0-based).
- frame_done  out  1  one-cycle strobe at reset gap after at least one bit.
- frame_pixels  out  8  pixel count of the last completed frame, held.
- err  out  1  one-cycle strobe on any protocol error.
- busy  out  1  high in HIGH or LOW states.

Behaviour:
- Reset (asynchronous, active-low): every output is 0; state ARM; synchronizer and din_d flops are 0; all counters are 0.
- Synchronizer: din passes through SYNC_STAGES flops to give din_s, and din_d = din_s delayed one cycle.
  - rise = din_s & ~din_d; fall = ~din_s & din_d.
- high_cnt: 6-bit, saturates at 63.
  - Loads 1 on rise; increments while din_s = 1.
- low_cnt: 12-bit, saturates.
  - Clears on rise; increments while din_s = 0.
- FSM states:
  - ARM: waits for low_cnt == RESET_CYCLES → READY. Any rise restarts the count. No decode in this state, so capture never starts mid-frame.
  - READY: line idle. rise → HIGH; bit_cnt and pix_cnt are 0.
  - HIGH: on fall, evaluate high_cnt.
    - < MIN_HIGH or > MAX_HIGH → err, → ARM, discard partial pixel.
    - Otherwise shift bit (high_cnt > BIT_THRESH) into the shift register LSB and increment bit_cnt → LOW.
    - If high_cnt saturates while still high → err, → ARM.
  - LOW: rise → HIGH. low_cnt == RESET_CYCLES → frame end, → READY.
- Pixel completion: on the fall that completes bit 23, with pix_cnt < MAX_PIXELS:
  - Next cycle: pixel_valid = 1, pixel_data = shift word, pixel_index = pix_cnt.
  - pix_cnt then increments and bit_cnt returns to 0.
- Overflow: if pix_cnt == MAX_PIXELS when bit 23 completes → err, no pixel_valid, stay in LOW (rest of frame ignored until gap).
- Latency: pixel_valid is high in the cycle following the (SYNC_STAGES+1)th sys_clk edge at/after the edge that first samples din low at the end of bit 23.
- Frame end (LOW, low_cnt reaches RESET_CYCLES):
  - frame_done = 1 for one cycle; frame_pixels = pix_cnt (0..128).
  - If bit_cnt != 0 (partial pixel), err = 1 in the same cycle and the partial bits are dropped.
  - pix_cnt and bit_cnt clear.
- Simultaneous events:
  - err and frame_done may assert together.
  - pixel_valid and err never assert together.
- Inter-bit low length is not checked below RESET_CYCLES.
- busy = 1 in HIGH or LOW.

Test Plan:
- Nominal frame: after 2600 low cycles, send 3 pixels 0x00FF00, 0xA5A5A5, 0x000001 with bit 0 = 11 cycles high / 45 low and bit 1 = 31 high / 25 low, then 2750 low → pixel_valid ×3 with indices 0, 1, 2 and exact data; frame_done once; frame_pixels = 3; err never.
- Startup mid-frame: release reset with bits already toggling, then 1000 low, then bits → no pixel_valid until after the first 2500-cycle low; the following frame decodes correctly.
- Threshold edges: high widths of 20 and 21 cycles → bits 0 and 1. Widths 3 and 46 → err, ARM, and the next frame after a gap decodes.
- Partial pixel: 30 bits then a gap → one pixel_valid, then frame_done with err in the same cycle; frame_pixels = 1.
- Overflow: 130 pixels → 128 pixel_valid strobes (indices 0..127); err on pixel 129 only; frame_done with frame_pixels = 128.
- Reset mid-pixel: assert sys_rst_n = 0 after 12 bits → all outputs 0 immediately; after release, ARM gating and a clean frame decodes.

Source files
------------

// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receiver: measures high-pulse widths on the strip line,
// rebuilds 24-bit GRB words MSB-first, counts pixels and flags frame end on the latch gap.
module ws2812_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_HIGH     = 4,
  parameter int BIT_THRESH   = 20,
  parameter int MAX_HIGH     = 45,
  parameter int RESET_CYCLES = 2500,
  parameter int MAX_PIXELS   = 128
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [6:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  frame_pixels,
  output logic        err,
  output logic        busy
);

  localparam logic [5:0]  MIN_HIGH_C   = 6'(MIN_HIGH);
  localparam logic [5:0]  MAX_HIGH_C   = 6'(MAX_HIGH);
  localparam logic [5:0]  BIT_THRESH_C = 6'(BIT_THRESH);
  localparam logic [11:0] RESET_C      = 12'(RESET_CYCLES);
  localparam logic [7:0]  MAX_PIX_C    = 8'(MAX_PIXELS);

  typedef enum logic [1:0] {ARM, READY, HIGH, LOW} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s, din_d, rise, fall;
  logic [5:0]             high_cnt;
  logic [11:0]            low_cnt;
  logic [4:0]             bit_cnt;
  logic [7:0]             pix_cnt;
  logic [23:0]            shift_q;
  logic                   ovf;
  logic                   bit_val, do_shift, do_err, do_frame, do_clr;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  assign din_s = sync_q[SYNC_STAGES-1];
  assign rise  = din_s & ~din_d;
  assign fall  = ~din_s & din_d;
  assign busy  = (state == HIGH) || (state == LOW);

  // Input synchronizer, edge history and pulse-width counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= '0;
      din_d    <= 1'b0;
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      din_d  <= din_s;
      if (rise) begin
        high_cnt <= 6'd1;
        low_cnt  <= '0;
      end else if (din_s) begin
        high_cnt <= sat_inc6(high_cnt);
      end else begin
        low_cnt  <= sat_inc12(low_cnt);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ARM;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    do_err    = 1'b0;
    do_frame  = 1'b0;
    do_clr    = 1'b0;
    bit_val   = (high_cnt > BIT_THRESH_C);
    case (state)
      // Capture only begins after a full idle gap, so a mid-frame start is never decoded
      ARM: begin
        do_clr = 1'b1;
        if (low_cnt == RESET_C) state_nxt = rise ? HIGH : READY;
      end
      READY: begin
        if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if ((high_cnt < MIN_HIGH_C) || (high_cnt > MAX_HIGH_C)) begin
            do_err    = 1'b1;
            state_nxt = ARM;
          end else begin
            do_shift  = 1'b1;
            state_nxt = LOW;
          end
        end else if (high_cnt == 6'h3f) begin
          do_err    = 1'b1;
          state_nxt = ARM;
        end
      end
      LOW: begin
        if (low_cnt == RESET_C) begin
          do_frame  = 1'b1;
          state_nxt = rise ? HIGH : READY;
        end else if (rise && !ovf) begin
          state_nxt = HIGH;
        end
      end
      default: state_nxt = ARM;
    endcase
  end

  // Bit assembly, pixel strobe and frame bookkeeping
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      ovf          <= 1'b0;
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      err          <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      err         <= do_err;
      if (do_clr) begin
        bit_cnt <= '0;
        pix_cnt <= '0;
        ovf     <= 1'b0;
      end
      if (do_shift) begin
        shift_q <= {shift_q[22:0], bit_val};
        if (bit_cnt == 5'd23) begin
          bit_cnt <= '0;
          if (pix_cnt < MAX_PIX_C) begin
            pixel_valid <= 1'b1;
            pixel_data  <= {shift_q[22:0], bit_val};
            pixel_index <= pix_cnt[6:0];
            pix_cnt     <= pix_cnt + 8'd1;
          end else begin
            // Frame too long: flag once, then ignore pulses until the latch gap
            err <= 1'b1;
            ovf <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (do_frame) begin
        frame_done   <= 1'b1;
        frame_pixels <= pix_cnt;
        err          <= (bit_cnt != 5'd0);
        bit_cnt      <= '0;
        pix_cnt      <= '0;
        ovf          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives NRZ waveforms on din and checks decoded
// pixels, frame strobes and error strobes against hand-computed values.
module tb_ws2812_rx;

  localparam int GAP = 2560;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        din;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [6:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixels;
  logic        err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  int pv_n     = 0;
  int err_n    = 0;
  int fd_n     = 0;
  int fd_err_n = 0;
  int both_n   = 0;
  logic [23:0] pv_data [0:511];
  logic [6:0]  pv_idx  [0:511];

  int b_pv, b_err, b_fd, b_fde;

  ws2812_rx dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .din         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .frame_pixels(frame_pixels),
    .err         (err),
    .busy        (busy)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Event recorder, sampled on the falling edge away from output updates
  always @(negedge sys_clk) begin
    if (pixel_valid) begin
      if (pv_n < 512) begin
        pv_data[pv_n] <= pixel_data;
        pv_idx[pv_n]  <= pixel_index;
      end
      pv_n <= pv_n + 1;
    end
    if (err)                      err_n    <= err_n + 1;
    if (frame_done)               fd_n     <= fd_n + 1;
    if (frame_done && err)        fd_err_n <= fd_err_n + 1;
    if (pixel_valid && err)       both_n   <= both_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_pv  = pv_n;
    b_err = err_n;
    b_fd  = fd_n;
    b_fde = fd_err_n;
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge sys_clk);
    din = 1'b0;
    repeat (lo) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(31, 25);
    else   pulse(11, 45);
  endtask

  task automatic send_pixel(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic fast_pixel(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) pulse(p[i] ? 22 : 6, 2);
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"}, 32'(pixel_data), 32'h0);
    chk({tag, "_ctl"}, 32'({pixel_valid, pixel_index, frame_done, frame_pixels, err, busy}), 32'h0);
  endtask

  initial begin
    int bad;
    sys_rst_n = 1'b0;
    din       = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_outputs_zero("reset");
    sys_rst_n = 1'b1;

    // Nominal three-pixel frame
    idle(2600);
    chk("ready_not_busy", 32'(busy), 32'h0);
    snap();
    send_pixel(24'h00FF00);
    send_pixel(24'hA5A5A5);
    send_pixel(24'h000001);
    idle(2750);
    chk("nom_pv_count", 32'(pv_n - b_pv), 32'd3);
    chk("nom_data0", 32'(pv_data[b_pv]),     32'h00FF00);
    chk("nom_data1", 32'(pv_data[b_pv + 1]), 32'hA5A5A5);
    chk("nom_data2", 32'(pv_data[b_pv + 2]), 32'h000001);
    chk("nom_idx0", 32'(pv_idx[b_pv]),     32'd0);
    chk("nom_idx1", 32'(pv_idx[b_pv + 1]), 32'd1);
    chk("nom_idx2", 32'(pv_idx[b_pv + 2]), 32'd2);
    chk("nom_fd_count", 32'(fd_n - b_fd), 32'd1);
    chk("nom_frame_pixels", 32'(frame_pixels), 32'd3);
    chk("nom_err_count", 32'(err_n - b_err), 32'd0);
    chk("nom_held_data", 32'(pixel_data), 32'h000001);

    // Startup mid-frame: reset released while bits are toggling
    sys_rst_n = 1'b0;
    pulse(31, 25);
    din = 1'b1;
    repeat (10) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    snap();
    repeat (21) @(negedge sys_clk);
    din = 1'b0;
    repeat (25) @(negedge sys_clk);
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    idle(1000);
    send_pixel(24'hFFFFFF);
    send_pixel(24'h00FF00);
    idle(100);
    chk("arm_no_pv", 32'(pv_n - b_pv), 32'd0);
    chk("arm_no_err", 32'(err_n - b_err), 32'd0);
    idle(GAP);
    chk("arm_no_fd", 32'(fd_n - b_fd), 32'd0);
    chk("arm_then_ready", 32'(busy), 32'h0);
    send_pixel(24'h123456);
    idle(GAP);
    chk("start_pv_count", 32'(pv_n - b_pv), 32'd1);
    chk("start_data", 32'(pv_data[b_pv]), 32'h123456);
    chk("start_idx", 32'(pv_idx[b_pv]), 32'd0);
    chk("start_frame_pixels", 32'(frame_pixels), 32'd1);

    // Threshold edges: 20 cycles decodes 0, 21 decodes 1
    snap();
    for (int i = 0; i < 12; i++) pulse(20, 20);
    for (int i = 0; i < 12; i++) pulse(21, 20);
    idle(GAP);
    chk("thr_data", 32'(pv_data[b_pv]), 32'h000FFF);
    chk("thr_err", 32'(err_n - b_err), 32'd0);

    // Too-short pulse aborts to ARM
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    pulse(3, 45);
    chk("short_err", 32'(err_n - b_err), 32'd1);
    chk("short_arm", 32'(busy), 32'h0);
    idle(GAP);
    chk("short_no_fd", 32'(fd_n - b_fd), 32'd0);
    send_pixel(24'h5A5A5A);
    idle(GAP);
    chk("short_recover", 32'(pv_data[b_pv]), 32'h5A5A5A);
    chk("short_pv_count", 32'(pv_n - b_pv), 32'd1);

    // Too-long pulse aborts to ARM
    snap();
    send_bit(1'b1);
    pulse(46, 45);
    chk("long_err", 32'(err_n - b_err), 32'd1);
    idle(GAP);
    send_pixel(24'hC3C3C3);
    idle(GAP);
    chk("long_recover", 32'(pv_data[b_pv]), 32'hC3C3C3);
    chk("long_pv_count", 32'(pv_n - b_pv), 32'd1);
    chk("long_fd_count", 32'(fd_n - b_fd), 32'd1);

    // Partial pixel at frame end
    snap();
    send_pixel(24'h0F0F0F);
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    idle(GAP);
    chk("part_pv_count", 32'(pv_n - b_pv), 32'd1);
    chk("part_data", 32'(pv_data[b_pv]), 32'h0F0F0F);
    chk("part_fd_with_err", 32'(fd_err_n - b_fde), 32'd1);
    chk("part_err_count", 32'(err_n - b_err), 32'd1);
    chk("part_frame_pixels", 32'(frame_pixels), 32'd1);

    // Overflow: 130 pixels, only 128 accepted
    snap();
    for (int i = 0; i < 130; i++) fast_pixel(24'(i));
    idle(GAP);
    chk("ovf_pv_count", 32'(pv_n - b_pv), 32'd128);
    bad = 0;
    for (int k = 0; k < 128; k++)
      if (pv_idx[b_pv + k] !== 7'(k) || pv_data[b_pv + k] !== 24'(k)) bad++;
    chk("ovf_sequence_bad", 32'(bad), 32'd0);
    chk("ovf_err_count", 32'(err_n - b_err), 32'd1);
    chk("ovf_fd_count", 32'(fd_n - b_fd), 32'd1);
    chk("ovf_frame_pixels", 32'(frame_pixels), 32'd128);
    chk("pv_err_overlap", 32'(both_n), 32'd0);

    // Reset mid-pixel clears everything asynchronously
    for (int i = 23; i >= 12; i--) send_bit(1'(24'hABCDEF >> i));
    chk("pre_rst_busy", 32'(busy), 32'h1);
    sys_rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    snap();
    send_pixel(24'hABCDEF);
    idle(GAP);
    chk("rst_arm_no_pv", 32'(pv_n - b_pv), 32'd0);
    chk("rst_arm_no_fd", 32'(fd_n - b_fd), 32'd0);
    send_pixel(24'h13579B);
    idle(GAP);
    chk("rst_pv_count", 32'(pv_n - b_pv), 32'd1);
    chk("rst_data", 32'(pv_data[b_pv]), 32'h13579B);
    chk("rst_idx", 32'(pv_idx[b_pv]), 32'd0);
    chk("rst_frame_pixels", 32'(frame_pixels), 32'd1);
    chk("rst_err_count", 32'(err_n - b_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
